// File: rtl/pkt_sched_arbiter.sv
//----------------------------------------------------------------------------
// pkt_sched_arbiter
//
// Packet-granular N-channel arbiter sitting between the per-port input FIFOs
// and the cache write path. One channel is chosen per packet, in either
// strict-priority (lowest index wins) or weighted-round-robin order. The
// grant is held from sop to eop. Words are popped from the granted FIFO
// head and presented on a single registered output stream.
//
// Optional feature macro: ARB_WDOG_EN
//   When defined, a stall watchdog aborts a grant that has not popped for
//   WDOG_CYC cycles and pulses wdog_err. When undefined, a stalled grant is
//   held indefinitely and the wdog_err port does not exist.
//
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   sp0_wrr1           0 = strict priority, 1 = weighted round robin
//   wrr_weight         per-channel weight, channel c at [c*WGT_W +: WGT_W]
//   in_sop/eop/vld     FIFO head flags, one bit per channel
//   in_data            FIFO head words, channel c at [c*DATA_W +: DATA_W]
//   pop                combinational pop of the granted FIFO head
//   out_ready          downstream accepts out_* this cycle
//   out_vld/sop/eop    registered output word flags
//   out_data, out_ch   registered output word and its source channel
//   busy               grant held (transfer in progress)
//   wdog_err           one-cycle stall-abort pulse (ARB_WDOG_EN only)
//----------------------------------------------------------------------------
`timescale 1ns/1ps

module pkt_sched_arbiter #(
    parameter int NUM_CH   = 16,
    parameter int DATA_W   = 64,
    parameter int CH_W     = 4,
    parameter int WGT_W    = 4,
    parameter int WDOG_CYC = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sp0_wrr1,
    input  logic [NUM_CH*WGT_W-1:0]  wrr_weight,
    input  logic [NUM_CH-1:0]        in_sop,
    input  logic [NUM_CH-1:0]        in_eop,
    input  logic [NUM_CH-1:0]        in_vld,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic [NUM_CH-1:0]        pop,
    input  logic                     out_ready,
    output logic                     out_vld,
    output logic                     out_sop,
    output logic                     out_eop,
    output logic [DATA_W-1:0]        out_data,
    output logic [CH_W-1:0]          out_ch,
    output logic                     busy
`ifdef ARB_WDOG_EN
    ,
    output logic                     wdog_err
`endif
);

    typedef enum logic {ARB = 1'b0, XFER = 1'b1} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CH_W-1:0]   grant;
    logic [CH_W-1:0]   rr_ptr;
    logic [WGT_W-1:0]  credit [NUM_CH];

    logic [NUM_CH-1:0] req;
    logic              any_req;
    logic [CH_W-1:0]   sp_win;
    logic              sp_found;
    logic [CH_W-1:0]   wrr_win;
    logic              wrr_found;
    logic [NUM_CH-1:0] wrr_skip;
    int                scan_idx;
    logic [CH_W-1:0]   win_ch;
    logic [WGT_W-1:0]  wgt_eff;
    logic [WGT_W-1:0]  cred_new;
    logic [CH_W-1:0]   wrr_win_next;
    logic [CH_W-1:0]   grant_next;
    logic              pop_en;
    logic              wdog_trip;

    // Only a valid start-of-packet head can request; stray mid-packet heads are ignored in ARB.
    assign req     = in_vld & in_sop;
    assign any_req = |req;

    // Strict priority: lowest-index requester.
    always_comb begin
        sp_win   = '0;
        sp_found = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (req[i] && !sp_found) begin
                sp_found = 1'b1;
                sp_win   = CH_W'(i);
            end
        end
    end

    // Round-robin scan from rr_ptr with wrap; channels passed over before the
    // winner are flagged so their partial credit can be forfeited.
    always_comb begin
        wrr_win   = '0;
        wrr_found = 1'b0;
        wrr_skip  = '0;
        scan_idx  = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            scan_idx = (int'(rr_ptr) + k) % NUM_CH;
            if (!wrr_found) begin
                if (req[scan_idx]) begin
                    wrr_found = 1'b1;
                    wrr_win   = CH_W'(scan_idx);
                end else begin
                    wrr_skip[scan_idx] = 1'b1;
                end
            end
        end
    end

    assign win_ch = sp0_wrr1 ? wrr_win : sp_win;

    // A zero weight behaves as one; a fresh grant loads weight-1 remaining repeats.
    always_comb begin
        wgt_eff = wrr_weight[int'(wrr_win)*WGT_W +: WGT_W];
        if (wgt_eff == '0) begin
            wgt_eff = WGT_W'(1);
        end
        if (credit[wrr_win] == '0) begin
            cred_new = wgt_eff - WGT_W'(1);
        end else begin
            cred_new = credit[wrr_win] - WGT_W'(1);
        end
    end

    assign wrr_win_next = (int'(wrr_win) == NUM_CH - 1) ? '0 : wrr_win + CH_W'(1);
    assign grant_next   = (int'(grant) == NUM_CH - 1) ? '0 : grant + CH_W'(1);

    // A word moves only when the output register is empty or being drained.
    assign pop_en = (state == XFER) && in_vld[grant] && (!out_vld || out_ready);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ARB;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: one ARB cycle per packet, leave XFER on the eop pop or a watchdog abort.
    always_comb begin
        state_nxt = state;
        case (state)
            ARB: begin
                if (any_req) begin
                    state_nxt = XFER;
                end
            end
            XFER: begin
                if (pop_en && in_eop[grant]) begin
                    state_nxt = ARB;
                end else if (wdog_trip) begin
                    state_nxt = ARB;
                end
            end
            default: state_nxt = ARB;
        endcase
    end

    // FSM outputs.
    always_comb begin
        pop        = '0;
        pop[grant] = pop_en;
        busy       = (state == XFER);
    end

    // Grant, round-robin pointer and credits change only at arbitration
    // (or when the watchdog gives up on the current owner).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant  <= '0;
            rr_ptr <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                credit[c] <= '0;
            end
        end else if (state == ARB && any_req) begin
            grant <= win_ch;
            if (sp0_wrr1) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (wrr_skip[c]) begin
                        credit[c] <= '0;
                    end
                end
                if (cred_new != '0) begin
                    credit[wrr_win] <= cred_new;
                    rr_ptr          <= wrr_win;
                end else begin
                    credit[wrr_win] <= '0;
                    rr_ptr          <= wrr_win_next;
                end
            end
        end else if (wdog_trip) begin
            rr_ptr <= grant_next;
        end
    end

    // Output register: load on pop, drain on ready, otherwise hold under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vld  <= 1'b0;
            out_sop  <= 1'b0;
            out_eop  <= 1'b0;
            out_data <= '0;
            out_ch   <= '0;
        end else if (pop_en) begin
            out_vld  <= 1'b1;
            out_sop  <= in_sop[grant];
            out_eop  <= in_eop[grant];
            out_data <= in_data[int'(grant)*DATA_W +: DATA_W];
            out_ch   <= grant;
        end else if (out_ready) begin
            out_vld  <= 1'b0;
        end
    end

`ifdef ARB_WDOG_EN
    localparam int WD_W = $clog2(WDOG_CYC + 1);

    logic [WD_W-1:0] stall_cnt;

    // Trips on the WDOG_CYC-th consecutive XFER cycle without a pop.
    assign wdog_trip = (state == XFER) && !pop_en && (stall_cnt == WD_W'(WDOG_CYC - 1));

    // Stall counter and abort pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            wdog_err  <= 1'b0;
        end else begin
            wdog_err <= wdog_trip;
            if (state != XFER || pop_en || wdog_trip) begin
                stall_cnt <= '0;
            end else begin
                stall_cnt <= stall_cnt + WD_W'(1);
            end
        end
    end
`else
    assign wdog_trip = 1'b0;
`endif

endmodule
